// File: rtl/persp_vertex_setup_if.sv
// persp_vertex_setup_if
//   Vertex-in / vertex-out bundle for the perspective setup unit.
//   Input side : in_valid/in_ready handshake, screen x/y (16-bit),
//                depth z and attributes u,v,r,g,b,a (32-bit S15.16).
//   Output side: out_valid/out_ready handshake, x/y/z passthrough,
//                w = 1/z and attr*w (32-bit S15.16).
//   slave  : the setup unit's view (consumes in_*, produces out_*).
//   master : the upstream/downstream environment's view.
interface persp_vertex_setup_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [31:0] in_z;
  logic [31:0] in_u;
  logic [31:0] in_v;
  logic [31:0] in_r;
  logic [31:0] in_g;
  logic [31:0] in_b;
  logic [31:0] in_a;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [31:0] out_z;
  logic [31:0] out_w;
  logic [31:0] out_u;
  logic [31:0] out_v;
  logic [31:0] out_r;
  logic [31:0] out_g;
  logic [31:0] out_b;
  logic [31:0] out_a;

  modport slave (
    input  in_valid, in_x, in_y, in_z, in_u, in_v, in_r, in_g, in_b, in_a,
    output in_ready,
    output out_valid, out_x, out_y, out_z, out_w,
    output out_u, out_v, out_r, out_g, out_b, out_a,
    input  out_ready
  );

  modport master (
    output in_valid, in_x, in_y, in_z, in_u, in_v, in_r, in_g, in_b, in_a,
    input  in_ready,
    input  out_valid, out_x, out_y, out_z, out_w,
    input  out_u, out_v, out_r, out_g, out_b, out_a,
    output out_ready
  );
endinterface

// File: rtl/persp_vertex_setup.sv
// persp_vertex_setup
//   Per-vertex perspective setup: w = 1/z (S15.16) via a 33-step bit-serial
//   restoring divide of 2^32 by z, then u,v,r,g,b,a are each multiplied by w
//   on one shared 32x32 signed multiplier, one attribute per cycle.
//   One vertex in flight; in_ready only while idle.
// Ports
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : persp_vertex_setup_if.slave (input vertex / output vertex)
// Parameter
//   BYPASS : 1 -> w = 1.0 and attributes pass through untouched.
module persp_vertex_setup #(
  parameter bit BYPASS = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  persp_vertex_setup_if.slave bus
);

  localparam logic [31:0] FP_ONE = 32'h0001_0000;
  localparam logic [31:0] W_SAT  = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [5:0]         cnt_r;
  logic [31:0]        rem_r;
  logic [31:0]        quo_r;
  logic [32:0]        rem_sh_s;
  logic [31:0]        rem_nxt_s;
  logic [32:0]        quo_nxt_s;
  logic               z_invalid_s;
  logic [15:0]        x_r;
  logic [15:0]        y_r;
  logic [31:0]        z_r;
  logic [31:0]        w_r;
  logic [31:0]        attr_r [0:5];
  logic [31:0]        mul_a_s;
  logic signed [63:0] prod_s;
  logic [31:0]        mul_res_s;
  logic [15:0]        out_x_r;
  logic [15:0]        out_y_r;
  logic [31:0]        out_z_r;
  logic [31:0]        out_w_r;
  logic [31:0]        out_attr_r [0:5];

  // Quotients of 2^31 and above do not fit a positive S15.16 value.
  function automatic logic [31:0] sat_w(input logic [32:0] q);
    if (q[32] | q[31]) begin
      return W_SAT;
    end else begin
      return q[31:0];
    end
  endfunction

  // Negative or zero depth has no meaningful reciprocal; it skips the divide.
  assign z_invalid_s = bus.in_z[31] | (bus.in_z == 32'd0);

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (BYPASS) begin
            state_nxt_s = ST_DONE;
          end else if (z_invalid_s) begin
            state_nxt_s = ST_MUL;
          end else begin
            state_nxt_s = ST_DIV;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (cnt_r == 6'd0) begin
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_MUL: begin
        if (cnt_r == 6'd5) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One restoring step. Numerator 2^32 has only its MSB set, which is
  // consumed when cnt_r is 32. The remainder stays below z (< 2^31), so the
  // low 32 bits of the difference are exact.
  always_comb begin
    rem_sh_s = {rem_r, (cnt_r == 6'd32)};
    if (rem_sh_s >= {1'b0, z_r}) begin
      rem_nxt_s = rem_sh_s[31:0] - z_r;
      quo_nxt_s = {quo_r, 1'b1};
    end else begin
      rem_nxt_s = rem_sh_s[31:0];
      quo_nxt_s = {quo_r, 1'b0};
    end
  end

  // Shared multiplier operand select: cnt_r walks u,v,r,g,b,a in MUL.
  always_comb begin
    case (cnt_r)
      6'd0:    mul_a_s = attr_r[0];
      6'd1:    mul_a_s = attr_r[1];
      6'd2:    mul_a_s = attr_r[2];
      6'd3:    mul_a_s = attr_r[3];
      6'd4:    mul_a_s = attr_r[4];
      6'd5:    mul_a_s = attr_r[5];
      default: mul_a_s = 32'd0;
    endcase
  end

  // 64-bit signed product; arithmetic >>> 16 floors, upper bits wrap away.
  assign prod_s    = $signed({{32{mul_a_s[31]}}, mul_a_s}) *
                     $signed({{32{w_r[31]}}, w_r});
  assign mul_res_s = 32'(prod_s >>> 7'd16);

  // Datapath: capture, divider iteration, multiply and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= 6'd0;
      rem_r   <= 32'd0;
      quo_r   <= 32'd0;
      x_r     <= 16'd0;
      y_r     <= 16'd0;
      z_r     <= 32'd0;
      w_r     <= 32'd0;
      out_x_r <= 16'd0;
      out_y_r <= 16'd0;
      out_z_r <= 32'd0;
      out_w_r <= 32'd0;
      for (int i = 0; i < 6; i++) begin
        attr_r[i]     <= 32'd0;
        out_attr_r[i] <= 32'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_r       <= bus.in_x;
            y_r       <= bus.in_y;
            z_r       <= bus.in_z;
            attr_r[0] <= bus.in_u;
            attr_r[1] <= bus.in_v;
            attr_r[2] <= bus.in_r;
            attr_r[3] <= bus.in_g;
            attr_r[4] <= bus.in_b;
            attr_r[5] <= bus.in_a;
            rem_r     <= 32'd0;
            quo_r     <= 32'd0;
            if (BYPASS) begin
              w_r           <= FP_ONE;
              cnt_r         <= 6'd0;
              out_x_r       <= bus.in_x;
              out_y_r       <= bus.in_y;
              out_z_r       <= bus.in_z;
              out_w_r       <= FP_ONE;
              out_attr_r[0] <= bus.in_u;
              out_attr_r[1] <= bus.in_v;
              out_attr_r[2] <= bus.in_r;
              out_attr_r[3] <= bus.in_g;
              out_attr_r[4] <= bus.in_b;
              out_attr_r[5] <= bus.in_a;
            end else if (z_invalid_s) begin
              w_r   <= W_SAT;
              cnt_r <= 6'd0;
            end else begin
              cnt_r <= 6'd32;
            end
          end
        end
        ST_DIV: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s[31:0];
          if (cnt_r == 6'd0) begin
            w_r <= sat_w(quo_nxt_s);
          end else begin
            cnt_r <= cnt_r - 6'd1;
          end
        end
        ST_MUL: begin
          out_x_r <= x_r;
          out_y_r <= y_r;
          out_z_r <= z_r;
          out_w_r <= w_r;
          for (int i = 0; i < 6; i++) begin
            if (cnt_r == 6'(i)) begin
              out_attr_r[i] <= mul_res_s;
            end
          end
          if (cnt_r == 6'd5) begin
            cnt_r <= 6'd0;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        ST_DONE: begin
          cnt_r <= 6'd0;
        end
        default: begin
          cnt_r <= 6'd0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_x     = out_x_r;
  assign bus.out_y     = out_y_r;
  assign bus.out_z     = out_z_r;
  assign bus.out_w     = out_w_r;
  assign bus.out_u     = out_attr_r[0];
  assign bus.out_v     = out_attr_r[1];
  assign bus.out_r     = out_attr_r[2];
  assign bus.out_g     = out_attr_r[3];
  assign bus.out_b     = out_attr_r[4];
  assign bus.out_a     = out_attr_r[5];

endmodule

// File: tb/tb_persp_vertex_setup.sv
// tb_persp_vertex_setup
//   Directed and randomized stimulus for persp_vertex_setup, checked against
//   an arithmetic reference (integer divide for 1/z, 64-bit multiply for
//   attr*w) and the documented handshake latencies.
module tb_persp_vertex_setup;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  persp_vertex_setup_if bus ();

  persp_vertex_setup #(.BYPASS(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0]      x;
    logic [15:0]      y;
    logic [31:0]      z;
    logic [5:0][31:0] attr;  // index 0..5 = u,v,r,g,b,a
  } vtx_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference: w = floor(2^32 / z), saturated; invalid depth saturates too.
  function automatic logic [31:0] model_w(input logic [31:0] z);
    logic [63:0] q;
    if (z[31] || z == 32'd0) return 32'h7FFF_FFFF;
    q = 64'h1_0000_0000 / {32'd0, z};
    if (q >= 64'h8000_0000) return 32'h7FFF_FFFF;
    return q[31:0];
  endfunction

  // Reference: floor((attr * w) / 2^16), wrapped to 32 bits.
  function automatic logic [31:0] model_attr(input logic [31:0] a, input logic [31:0] w);
    longint p;
    p = longint'($signed(a)) * longint'($signed(w));
    p = p >>> 16;
    return p[31:0];
  endfunction

  function automatic int model_lat(input logic [31:0] z);
    if (z[31] || z == 32'd0) return 7;
    return 40;
  endfunction

  function automatic vtx_t mk_vtx(input logic [31:0] z, input logic [31:0] u, input logic [31:0] r);
    vtx_t v;
    v.x = 16'($urandom);
    v.y = 16'($urandom);
    v.z = z;
    for (int i = 0; i < 6; i++) v.attr[i] = $urandom;
    v.attr[0] = u;
    v.attr[2] = r;
    return v;
  endfunction

  task automatic put_inputs(input vtx_t v);
    bus.in_x = v.x;
    bus.in_y = v.y;
    bus.in_z = v.z;
    bus.in_u = v.attr[0];
    bus.in_v = v.attr[1];
    bus.in_r = v.attr[2];
    bus.in_g = v.attr[3];
    bus.in_b = v.attr[4];
    bus.in_a = v.attr[5];
  endtask

  // Presents a vertex and returns just after the accepting posedge.
  task automatic accept(input vtx_t v, input string tag);
    int k;
    @(negedge clk);
    put_inputs(v);
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_accept_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
  endtask

  // Called right after the accept edge; returns at the negedge where out_valid is seen.
  task automatic wait_out(input int exp_lat, input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
    while (!bus.out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt + 1), 32'(exp_lat));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic check_out(input vtx_t v, input string tag);
    logic [31:0] w;
    w = model_w(v.z);
    chk({tag, "_x"}, 32'(bus.out_x), 32'(v.x));
    chk({tag, "_y"}, 32'(bus.out_y), 32'(v.y));
    chk({tag, "_z"}, bus.out_z, v.z);
    chk({tag, "_w"}, bus.out_w, w);
    chk({tag, "_u"}, bus.out_u, model_attr(v.attr[0], w));
    chk({tag, "_v"}, bus.out_v, model_attr(v.attr[1], w));
    chk({tag, "_r"}, bus.out_r, model_attr(v.attr[2], w));
    chk({tag, "_g"}, bus.out_g, model_attr(v.attr[3], w));
    chk({tag, "_b"}, bus.out_b, model_attr(v.attr[4], w));
    chk({tag, "_a"}, bus.out_a, model_attr(v.attr[5], w));
  endtask

  // Holds out_ready low for 'hold' cycles checking stability, then handshakes.
  task automatic release_out(input vtx_t v, input int hold, input string tag);
    logic [31:0] w;
    w = model_w(v.z);
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_w"}, bus.out_w, w);
      chk({tag, "_hold_a"}, bus.out_a, model_attr(v.attr[5], w));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_vertex(input vtx_t v, input int hold, input string tag);
    accept(v, tag);
    wait_out(model_lat(v.z), tag);
    check_out(v, tag);
    release_out(v, hold, tag);
  endtask

  initial begin : stim
    vtx_t va;
    vtx_t vb;
    int   sel;
    int   stray;
    logic [31:0] z;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    put_inputs('0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_w", bus.out_w, 32'd0);
    chk("rst_out_u", bus.out_u, 32'd0);
    rst_n = 1'b1;

    // Unit depth
    va = mk_vtx(32'h0001_0000, 32'h0003_0000, 32'h0000_0000);
    accept(va, "unit");
    wait_out(40, "unit");
    check_out(va, "unit");
    chk("unit_w_lit", bus.out_w, 32'h0001_0000);
    chk("unit_u_lit", bus.out_u, 32'h0003_0000);
    release_out(va, 2, "unit");

    // Depth 2.0 with negative attribute
    va = mk_vtx(32'h0002_0000, 32'h0001_0000, 32'hFFFF_0000);
    accept(va, "d2");
    wait_out(40, "d2");
    check_out(va, "d2");
    chk("d2_w_lit", bus.out_w, 32'h0000_8000);
    chk("d2_u_lit", bus.out_u, 32'h0000_8000);
    chk("d2_r_lit", bus.out_r, 32'hFFFF_8000);
    release_out(va, 0, "d2");

    // Truncation
    va = mk_vtx(32'h0003_0000, 32'h0003_0000, 32'h0);
    accept(va, "trunc");
    wait_out(40, "trunc");
    check_out(va, "trunc");
    chk("trunc_w_lit", bus.out_w, 32'h0000_5555);
    chk("trunc_u_lit", bus.out_u, 32'h0000_FFFF);
    release_out(va, 1, "trunc");

    // Saturation: tiny z through the divider, zero/negative z skip it
    va = mk_vtx(32'h0000_0001, $urandom, $urandom);
    run_vertex(va, 0, "sat_z1");
    chk("sat_z1_w_lit", bus.out_w, 32'h7FFF_FFFF);
    va = mk_vtx(32'h0000_0000, $urandom, $urandom);
    run_vertex(va, 0, "sat_z0");
    chk("sat_z0_w_lit", bus.out_w, 32'h7FFF_FFFF);
    va = mk_vtx(32'hFFFF_0000, $urandom, $urandom);
    run_vertex(va, 1, "sat_neg");
    chk("sat_neg_w_lit", bus.out_w, 32'h7FFF_FFFF);

    // Backpressure with a second vertex waiting
    va = mk_vtx(32'h0003_0000, $urandom, $urandom);
    vb = mk_vtx(32'h0005_0000, $urandom, $urandom);
    accept(va, "bpA");
    wait_out(40, "bpA");
    put_inputs(vb);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_w", bus.out_w, model_w(va.z));
      chk("bp_u", bus.out_u, model_attr(va.attr[0], model_w(va.z)));
    end
    check_out(va, "bpA");
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_hs_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    wait_out(40, "bpB");
    check_out(vb, "bpB");
    release_out(vb, 0, "bpB");

    // Reset in the middle of the divide
    va = mk_vtx(32'h0004_0000, $urandom, $urandom);
    accept(va, "rst");
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rstmid_out_w", bus.out_w, 32'd0);
    stray = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    chk("rstmid_no_output", 32'(stray), 32'd0);
    va = mk_vtx(32'h0002_0000, $urandom, $urandom);
    run_vertex(va, 0, "after_rst");
    chk("after_rst_w_lit", bus.out_w, 32'h0000_8000);

    // Randomized vertices
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       z = $urandom;
        1:       z = $urandom_range(1, 32'h0003_FFFF);
        2:       z = (32'h0001_0000 * $urandom_range(1, 64)) + $urandom_range(0, 32'hFFFF);
        default: z = $urandom & 32'h7FFF_FFFF;
      endcase
      va = mk_vtx(z, $urandom, $urandom);
      run_vertex(va, $urandom_range(0, 3), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/persp_vertex_setup.md
# persp_vertex_setup

Per-vertex perspective setup unit: accepts a projected vertex with depth z (S15.16), computes w = 1/z with a bit-serial restoring divider, and premultiplies u, v, r, g, b, a by w. It feeds the rasterizer's triangle setup. The rasterizer interpolates attr*w and w across the triangle, and perspective_correct divides by w per fragment. It is a multi-cycle, single-vertex-in-flight block that uses one shared 32x32 signed multiplier.

## Interface
- BYPASS, 0: when 1, w_out = FP_ONE and all attributes pass through unmodified.
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  input vertex valid
- in_ready  out  1  high only in IDLE
- in_x, in_y  in  screen_coord_t  screen position
- in_z  in  fp32_t  depth, S15.16
- in_u, in_v, in_r, in_g, in_b, in_a  in  fp32_t (32)  attributes, S15.16 signed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_x, out_y  out  screen_coord_t  passthrough
- out_z  out  fp32_t  passthrough
- out_w  out  fp32_t  1/z, S15.16
- out_u … out_a  out  fp32_t  attr*w, S15.16

## Operation
- States: IDLE, DIV, MUL, DONE.
- IDLE: in_ready=1. On an edge with in_valid, capture all inputs.
  - BYPASS=1: set w=FP_ONE, copy the attributes, and go to DONE.
  - in_z[31]=1 or in_z=0: set w=0x7FFFFFFF and go to MUL. The divide is skipped.
  - Otherwise go to DIV, with remainder=0 and counter=32.
- DIV: performs one restoring step per edge, 33 steps in total.
  - Numerator is 2^32 (33 bits, MSB first); divisor is z, unsigned.
  - Each step: rem = {rem, next numerator bit}. If rem >= z, subtract z and shift in quotient bit 1; otherwise shift in 0.
  - After the last step, go to MUL.
  - Quotient truncates toward zero. If quotient bit 32 or bit 31 is set, saturate w to 0x7FFFFFFF.
- MUL: performs one attribute per edge, in the order u, v, r, g, b, a (6 edges).
  - out_attr = low 32 bits of ((64-bit signed attr * signed w) >>> 16).
  - The shift is arithmetic and truncates toward −∞. Overflow wraps (no saturation).
  - After a, go to DONE.
- DONE: out_valid=1. On the edge where out_ready is high, go to IDLE.
- x, y, z pass through unchanged.

## Timing
- Reset values: out_valid=0 and all data outputs 0. State resets to IDLE, so in_ready reads 1 during and after reset.
- Reset mid-operation aborts the vertex, which is dropped with no output. The next vertex after reset is processed normally.
- Let edge T be the input handshake edge. out_valid rises after:
  - edge T+39 in the normal path (40 cycles of latency);
  - edge T+6 in the invalid-z path;
  - edge T in BYPASS.
- Throughput: one vertex per 41 cycles when out_ready is held high. in_ready is low in DIV, MUL and DONE.
- Backpressure in DONE:
  - while out_valid=1 and out_ready=0, all outputs hold stable;
  - out_valid falls on the edge where out_ready=1;
  - no new input is accepted in the same edge.
- Output data registers update only in MUL (or at capture in BYPASS). The out_* values are stable from out_valid rising until the handshake.
- out_valid never deasserts without a handshake, except on reset.

## Test plan
- **Unit depth:** z=0x00010000, u=0x00030000 -> w=0x00010000, u_out=0x00030000. out_valid appears exactly 40 cycles after accept. x, y, z are unchanged.
- **Depth 2.0, negative attribute:** z=0x00020000, u=0x00010000, r=0xFFFF0000 -> w=0x00008000, u_out=0x00008000, r_out=0xFFFF8000.
- **Truncation:** z=0x00030000, u=0x00030000 -> w=0x00005555, u_out=0x0000FFFF.
- **Saturation:**
  - z=0x00000001 -> w=0x7FFFFFFF after the full 40-cycle latency.
  - z=0 and z=0xFFFF0000 -> w=0x7FFFFFFF with 7-cycle latency.
- **Backpressure:** hold out_ready=0 for 10 cycles in DONE, with in_valid held high carrying a second vertex.
  - Outputs stay stable and in_ready=0.
  - The second vertex is accepted 1 cycle after the output handshake and completes correctly.
- **Reset mid-DIV:** assert rst_n=0 for 1 cycle, 20 cycles after accept -> out_valid=0 and in_ready=1. Next vertex z=0x00020000 gives w=0x00008000.
